// File: rtl/l2_req_arbiter_if.sv
// Bus bundle between the L2 request arbiter, its requesters and the L2 channel.
// The master modport is the arbiter's view; slave is the surrounding system.
interface l2_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ),
    parameter int TAG_W  = 4,
    parameter int REQ_W  = 64,
    parameter int RESP_W = 64
);
    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ*TAG_W-1:0] i_req_tag;
    logic [N_REQ*REQ_W-1:0] i_req_payload;
    logic [N_REQ-1:0]       o_req_ready;
    logic                   o_l2_req_valid;
    logic [ID_W+TAG_W-1:0]  o_l2_req_tag;
    logic [REQ_W-1:0]       o_l2_req_payload;
    logic                   i_l2_req_ready;
    logic                   i_l2_resp_valid;
    logic [ID_W+TAG_W-1:0]  i_l2_resp_tag;
    logic [RESP_W-1:0]      i_l2_resp_payload;
    logic                   o_l2_resp_ready;
    logic [N_REQ-1:0]       o_resp_valid;
    logic [TAG_W-1:0]       o_resp_tag;
    logic [RESP_W-1:0]      o_resp_payload;
    logic [N_REQ-1:0]       i_resp_ready;
    logic                   o_err_unroutable;

    modport master (
        input  i_req_valid, i_req_tag, i_req_payload,
        output o_req_ready,
        output o_l2_req_valid, o_l2_req_tag, o_l2_req_payload,
        input  i_l2_req_ready,
        input  i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_payload,
        output o_l2_resp_ready,
        output o_resp_valid, o_resp_tag, o_resp_payload,
        input  i_resp_ready,
        output o_err_unroutable
    );

    modport slave (
        output i_req_valid, i_req_tag, i_req_payload,
        input  o_req_ready,
        input  o_l2_req_valid, o_l2_req_tag, o_l2_req_payload,
        output i_l2_req_ready,
        output i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_payload,
        input  o_l2_resp_ready,
        input  o_resp_valid, o_resp_tag, o_resp_payload,
        output i_resp_ready,
        input  o_err_unroutable
    );
endinterface

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one L2 request channel among N_REQ requesters.
// Granted requests land in a one-entry output stage tagged with the requester
// ID; responses are routed back by that ID, and per-requester outstanding
// counters cap how many requests each requester may have in flight.
module l2_req_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int TAG_W     = 4,
    parameter int REQ_W     = 64,
    parameter int RESP_W    = 64,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST+1)
) (
    input logic              i_clk,
    input logic              i_reset,
    l2_req_arbiter_if.master io_bus
);

    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt [N_REQ];
    logic              r_l2_req_vld_p1;
    logic [ID_W+TAG_W-1:0] r_l2_req_tag_p1;
    logic [REQ_W-1:0]  r_l2_req_pay_p1;
    logic              r_err;

    logic              w_stage_free;
    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_cnt_zero;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_gnt_any;
    logic [ID_W-1:0]   w_gnt_id;
    logic [TAG_W-1:0]  w_gnt_tag;
    logic [REQ_W-1:0]  w_gnt_pay;
    logic [ID_W-1:0]   w_resp_id;
    logic [N_REQ-1:0]  w_resp_sel;
    logic              w_id_ok;
    logic              w_l2_resp_ready;
    logic [N_REQ-1:0]  w_dec;
    logic              w_bad_resp;
    logic [RESP_W-1:0] w_resp_payload;

    assign w_stage_free = !r_l2_req_vld_p1 || io_bus.i_l2_req_ready;

    // A requester is eligible while it is asking and still under its outstanding cap.
    always_comb begin
        w_elig     = '0;
        w_cnt_zero = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i]     = io_bus.i_req_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
            w_cnt_zero[i] = (r_cnt[i] == '0);
        end
    end

    // Round-robin search starting at r_rr_ptr; only one requester wins per cycle.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_gnt_tag = '0;
        w_gnt_pay = '0;
        if (w_stage_free) begin
            for (int off = 0; off < N_REQ; off++) begin
                idx = int'(r_rr_ptr) + off;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!w_gnt_any && w_elig[idx]) begin
                    w_gnt_any  = 1'b1;
                    w_gnt[idx] = 1'b1;
                    w_gnt_id   = ID_W'(idx);
                    w_gnt_tag  = io_bus.i_req_tag[idx*TAG_W +: TAG_W];
                    w_gnt_pay  = io_bus.i_req_payload[idx*REQ_W +: REQ_W];
                end
            end
        end
    end

    assign io_bus.o_req_ready = w_gnt;

    // Decode the returned ID; IDs with no matching requester are dropped but accepted.
    assign w_resp_id = io_bus.i_l2_resp_tag[ID_W+TAG_W-1:TAG_W];
    always_comb begin
        w_resp_sel      = '0;
        w_id_ok         = 1'b0;
        w_l2_resp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_resp_id == ID_W'(i)) begin
                w_resp_sel[i]   = 1'b1;
                w_id_ok         = 1'b1;
                w_l2_resp_ready = io_bus.i_resp_ready[i];
            end
        end
    end

    assign w_dec          = w_resp_sel & io_bus.i_resp_ready & {N_REQ{io_bus.i_l2_resp_valid}};
    assign w_bad_resp     = io_bus.i_l2_resp_valid && (!w_id_ok || |(w_dec & w_cnt_zero));
    assign w_resp_payload = io_bus.i_l2_resp_payload;

    assign io_bus.o_resp_valid     = w_resp_sel & {N_REQ{io_bus.i_l2_resp_valid}};
    assign io_bus.o_l2_resp_ready  = w_l2_resp_ready;
    assign io_bus.o_resp_tag       = io_bus.i_l2_resp_tag[TAG_W-1:0];
    assign io_bus.o_resp_payload   = w_resp_payload;

    // Output stage: load on grant, drain when L2 takes it, hold while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_l2_req_vld_p1 <= 1'b0;
            r_l2_req_tag_p1 <= '0;
            r_l2_req_pay_p1 <= '0;
            r_rr_ptr        <= '0;
        end else if (w_gnt_any) begin
            r_l2_req_vld_p1 <= 1'b1;
            r_l2_req_tag_p1 <= {w_gnt_id, w_gnt_tag};
            r_l2_req_pay_p1 <= w_gnt_pay;
            r_rr_ptr        <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        end else if (io_bus.i_l2_req_ready) begin
            r_l2_req_vld_p1 <= 1'b0;
        end
    end

    assign io_bus.o_l2_req_valid   = r_l2_req_vld_p1;
    assign io_bus.o_l2_req_tag     = r_l2_req_tag_p1;
    assign io_bus.o_l2_req_payload = r_l2_req_pay_p1;

    // Outstanding counters: +1 on request handshake, -1 on response handshake, floor at 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_gnt[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!w_gnt[i] && w_dec[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky flag for unroutable responses or responses with nothing outstanding.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (w_bad_resp) begin
            r_err <= 1'b1;
        end
    end

    assign io_bus.o_err_unroutable = r_err;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a behavioural model of the rules.
module tb_l2_req_arbiter;
    localparam int N    = 4;
    localparam int TW   = 4;
    localparam int RW   = 64;
    localparam int PW   = 64;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_req_arbiter_if #(.N_REQ(N), .TAG_W(TW), .REQ_W(RW), .RESP_W(PW)) bus ();

    l2_req_arbiter #(.N_REQ(N), .TAG_W(TW), .REQ_W(RW), .RESP_W(PW), .MAX_OUTST(MAXO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_cnt [N];
    int          m_ptr;
    bit          m_vld;
    logic [5:0]  m_tag;
    logic [63:0] m_pay;
    bit          m_err;

    // Expected combinational values for the current cycle
    int          exp_grant;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_resp_valid;
    logic        exp_l2_resp_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.i_req_valid       = '0;
        bus.i_req_tag         = '0;
        bus.i_req_payload     = '0;
        bus.i_l2_req_ready    = 1'b0;
        bus.i_l2_resp_valid   = 1'b0;
        bus.i_l2_resp_tag     = '0;
        bus.i_l2_resp_payload = '0;
        bus.i_resp_ready      = '0;
    endtask

    task automatic set_req(input int i, input logic [3:0] t, input logic [63:0] p);
        bus.i_req_tag[i*TW +: TW]     = t;
        bus.i_req_payload[i*RW +: RW] = p;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0;
        m_vld = 0;
        m_tag = '0;
        m_pay = '0;
        m_err = 0;
    endtask

    // Grant = first requester from the pointer that is asking and below its cap.
    task automatic model_comb();
        int id;
        exp_grant = -1;
        if (!m_vld || bus.i_l2_req_ready) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (exp_grant < 0 && bus.i_req_valid[k] && m_cnt[k] < MAXO) exp_grant = k;
            end
        end
        exp_ready = (exp_grant >= 0) ? 4'(1 << exp_grant) : 4'b0000;
        id = int'(bus.i_l2_resp_tag[5:4]);
        exp_resp_valid    = bus.i_l2_resp_valid ? 4'(1 << id) : 4'b0000;
        exp_l2_resp_ready = bus.i_resp_ready[id];
    endtask

    task automatic model_update();
        int inc [N];
        int dec [N];
        int id;
        for (int i = 0; i < N; i++) begin
            inc[i] = 0;
            dec[i] = 0;
        end
        if (exp_grant >= 0) inc[exp_grant] = 1;
        if (bus.i_l2_resp_valid) begin
            id = int'(bus.i_l2_resp_tag[5:4]);
            if (bus.i_resp_ready[id]) begin
                dec[id] = 1;
                if (m_cnt[id] == 0) m_err = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = m_cnt[i] + inc[i] - dec[i];
            if (m_cnt[i] < 0) m_cnt[i] = 0;
        end
        if (exp_grant >= 0) begin
            m_vld = 1;
            m_tag = {2'(exp_grant), bus.i_req_tag[exp_grant*TW +: TW]};
            m_pay = bus.i_req_payload[exp_grant*RW +: RW];
            m_ptr = (exp_grant + 1) % N;
        end else if (bus.i_l2_req_ready) begin
            m_vld = 0;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        #1;
        model_comb();
        check("req_ready",      64'(bus.o_req_ready),      64'(exp_ready));
        check("l2_req_valid",   64'(bus.o_l2_req_valid),   64'(m_vld));
        check("l2_req_tag",     64'(bus.o_l2_req_tag),     64'(m_tag));
        check("l2_req_payload", bus.o_l2_req_payload,      m_pay);
        check("resp_valid",     64'(bus.o_resp_valid),     64'(exp_resp_valid));
        check("l2_resp_ready",  64'(bus.o_l2_resp_ready),  64'(exp_l2_resp_ready));
        check("resp_tag",       64'(bus.o_resp_tag),       64'(bus.i_l2_resp_tag[3:0]));
        check("resp_payload",   bus.o_resp_payload,        bus.i_l2_resp_payload);
        check("err_unroutable", 64'(bus.o_err_unroutable), 64'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check("rst_l2_req_valid",   64'(bus.o_l2_req_valid),   64'd0);
        check("rst_l2_req_tag",     64'(bus.o_l2_req_tag),     64'd0);
        check("rst_l2_req_payload", bus.o_l2_req_payload,      64'd0);
        check("rst_err",            64'(bus.o_err_unroutable), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        clear_inputs();
        model_reset();

        // Single request from requester 1
        do_reset();
        bus.i_l2_req_ready = 1'b1;
        bus.i_req_valid    = 4'b0010;
        set_req(1, 4'h3, 64'hA5);
        compare();
        check("t1_ready", 64'(bus.o_req_ready), 64'b0010);
        tick();
        bus.i_req_valid = 4'b0000;
        compare();
        check("t1_valid",   64'(bus.o_l2_req_valid), 64'd1);
        check("t1_tag",     64'(bus.o_l2_req_tag),   64'h13);
        check("t1_payload", bus.o_l2_req_payload,    64'hA5);
        check("t1_model_cnt1", 64'(m_cnt[1]), 64'd1);
        tick();

        // All requesters valid: strict rotation
        do_reset();
        bus.i_l2_req_ready = 1'b1;
        bus.i_req_valid    = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 4'(i + 8), 64'(c * 16 + i));
            compare();
            check("t2_rr_order", 64'(bus.o_req_ready), 64'(1 << seq[c]));
            tick();
        end

        // Stall: stage full, nothing granted, contents held
        bus.i_l2_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 4'(c), 64'hDEAD_0000 + 64'(c * 4 + i));
            compare();
            check("t3_stall_ready", 64'(bus.o_req_ready),   64'd0);
            check("t3_hold_tag",    64'(bus.o_l2_req_tag),  64'h19);
            check("t3_hold_pay",    bus.o_l2_req_payload,   64'd81);
            tick();
        end
        bus.i_l2_req_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 8), 64'(100 + i));
        compare();
        check("t3_release_grant", 64'(bus.o_req_ready), 64'b0100);
        tick();
        bus.i_req_valid = 4'b0000;
        compare();
        check("t3_new_tag", 64'(bus.o_l2_req_tag), 64'h2A);
        tick();

        // Outstanding cap on requester 2
        do_reset();
        bus.i_l2_req_ready = 1'b1;
        bus.i_req_valid    = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            compare();
            check("t4_fill", 64'(bus.o_req_ready), 64'b0100);
            tick();
        end
        bus.i_req_valid = 4'b0101;
        compare();
        check("t4_capped", 64'(bus.o_req_ready), 64'b0001);
        tick();
        bus.i_l2_resp_valid   = 1'b1;
        bus.i_l2_resp_tag     = 6'b10_0111;
        bus.i_l2_resp_payload = 64'h1234;
        bus.i_resp_ready      = 4'b0100;
        compare();
        check("t4_still_capped", 64'(bus.o_req_ready),  64'b0001);
        check("t4_resp_valid",   64'(bus.o_resp_valid), 64'b0100);
        tick();
        bus.i_l2_resp_valid = 1'b0;
        bus.i_req_valid     = 4'b0100;
        compare();
        check("t4_reenabled", 64'(bus.o_req_ready), 64'b0100);
        tick();

        // Response routing to requester 3 and simultaneous inc/dec
        do_reset();
        bus.i_l2_req_ready = 1'b1;
        bus.i_req_valid    = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            compare();
            check("t5_grant3", 64'(bus.o_req_ready), 64'b1000);
            tick();
        end
        bus.i_req_valid       = 4'b0000;
        bus.i_l2_resp_valid   = 1'b1;
        bus.i_l2_resp_tag     = 6'b11_0101;
        bus.i_l2_resp_payload = 64'hCAFE;
        bus.i_resp_ready      = 4'b0000;
        compare();
        check("t5_resp_valid",    64'(bus.o_resp_valid),    64'b1000);
        check("t5_resp_notready", 64'(bus.o_l2_resp_ready), 64'd0);
        check("t5_resp_tag",      64'(bus.o_resp_tag),      64'h5);
        tick();
        bus.i_resp_ready = 4'b1000;
        compare();
        check("t5_resp_ready", 64'(bus.o_l2_resp_ready), 64'd1);
        tick();
        bus.i_req_valid = 4'b1000;
        compare();
        check("t5_simul_grant", 64'(bus.o_req_ready), 64'b1000);
        tick();
        bus.i_l2_resp_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            compare();
            check("t5_refill", 64'(bus.o_req_ready), (c < 3) ? 64'b1000 : 64'b0000);
            tick();
        end

        // Response with nothing outstanding, then asynchronous reset
        do_reset();
        bus.i_l2_req_ready    = 1'b1;
        bus.i_l2_resp_valid   = 1'b1;
        bus.i_l2_resp_tag     = 6'b00_0001;
        bus.i_resp_ready      = 4'b0001;
        compare();
        check("t6_fwd_valid", 64'(bus.o_resp_valid),    64'b0001);
        check("t6_fwd_ready", 64'(bus.o_l2_resp_ready), 64'd1);
        tick();
        bus.i_l2_resp_valid = 1'b0;
        bus.i_req_valid     = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            compare();
            check("t6_err_set",  64'(bus.o_err_unroutable), 64'd1);
            check("t6_cnt_floor", 64'(bus.o_req_ready),     64'b0001);
            tick();
        end
        bus.i_req_valid    = 4'b0000;
        bus.i_l2_req_ready = 1'b0;
        compare();
        check("t6_stage_full", 64'(bus.o_l2_req_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_vld", 64'(bus.o_l2_req_valid),   64'd0);
        check("t6_async_err", 64'(bus.o_err_unroutable), 64'd0);
        check("t6_async_tag", 64'(bus.o_l2_req_tag),     64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.i_l2_req_ready = 1'b1;
        bus.i_req_valid    = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            compare();
            check("t6_cnt_cleared", 64'(bus.o_req_ready), 64'b0001);
            tick();
        end

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int id;
            bus.i_req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) set_req(i, 4'($urandom), {$urandom, $urandom});
            bus.i_l2_req_ready    = ($urandom_range(0, 3) != 0);
            id                    = $urandom_range(0, N - 1);
            bus.i_l2_resp_valid   = (m_cnt[id] > 0) && ($urandom_range(0, 1) == 1);
            bus.i_l2_resp_tag     = {2'(id), 4'($urandom)};
            bus.i_l2_resp_payload = {$urandom, $urandom};
            bus.i_resp_ready      = 4'($urandom);
            compare();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
